event_ctr: RTL and testbench

- Parameterised up-counter that counts qualified events, either rising edges of TICK or every enabled ACLK cycle.
- Flags when the count equals a runtime TARGET.
- Optionally restarts from a runtime INITIAL value after the target is reached.
- Used as a generic timeout/event-count primitive inside AXI-clocked subsystems.

---
 rtl/event_ctr_pkg.sv | 12 +
 rtl/event_ctr_edge_det.sv | 42 ++++
 rtl/event_ctr.sv | 75 +++++++
 tb/tb_event_ctr.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/event_ctr_pkg.sv
// Shared constants and helpers for the event_ctr block.
// Holds the default counter width and a width-derived max-count helper.
package event_ctr_pkg;

    localparam int DEFAULT_TARGET_WIDTH = 4;

    // All-ones value for a counter of the given width; the point where the count wraps to zero.
    function automatic int max_count(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/event_ctr_edge_det.sv
// Rising-edge detector for the TICK event input of event_ctr.
// Defining EVENT_CTR_TICK_SYNC_EN adds a two-flop synchroniser ahead of the detector (+2 cycles latency).
module event_ctr_edge_det
    import event_ctr_pkg::*;
(
    input  logic aclk_i,
    input  logic aresetn_i,
    input  logic tick_i,
    output logic tick_rise_o
);

    logic tick_src;
    logic tick_q;

`ifdef EVENT_CTR_TICK_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchroniser so TICK may arrive asynchronously to ACLK.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], tick_i};
        end
    end

    assign tick_src = sync_q[1];
`else
    assign tick_src = tick_i;
`endif

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_src;
        end
    end

    assign tick_rise_o = tick_src & ~tick_q;

endmodule

// File: rtl/event_ctr.sv
// Up-counter of qualified events (TICK rises or enabled ACLK cycles) with a registered TARGET match flag.
// Optional macro EVENT_CTR_TICK_SYNC_EN synchronises TICK inside event_ctr_edge_det.
module event_ctr
    import event_ctr_pkg::*;
#(
    parameter int TARGET_WIDTH     = DEFAULT_TARGET_WIDTH,
    parameter int EVENT_IS_CLOCK   = 0,
    parameter int HAS_ENABLE       = 1,
    parameter int RESET_IF_REACHED = 1
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    ENABLE,
    input  logic [TARGET_WIDTH-1:0] INITIAL,
    input  logic [TARGET_WIDTH-1:0] TARGET,
    input  logic                    TICK,
    output logic                    REACHED,
    output logic [TARGET_WIDTH-1:0] COUNTER
);

    localparam logic [TARGET_WIDTH-1:0] COUNT_MAX = TARGET_WIDTH'(max_count(TARGET_WIDTH));
    localparam logic [TARGET_WIDTH-1:0] COUNT_ONE = TARGET_WIDTH'(1);

    logic [TARGET_WIDTH-1:0] counter_q;
    logic [TARGET_WIDTH-1:0] counter_d;
    logic                    reached_q;
    logic                    load_pending_q;
    logic                    tick_rise;
    logic                    en_eff;
    logic                    event_hit;

    event_ctr_edge_det u_edge_det (
        .aclk_i      (ACLK),
        .aresetn_i   (ARESETN),
        .tick_i      (TICK),
        .tick_rise_o (tick_rise)
    );

    assign en_eff    = (HAS_ENABLE != 0) ? ENABLE : 1'b1;
    assign event_hit = en_eff & ((EVENT_IS_CLOCK != 0) ? 1'b1 : tick_rise);

    // At TARGET an event either reloads INITIAL or saturates; otherwise count up with wrap.
    always_comb begin
        counter_d = counter_q;
        if (event_hit && !load_pending_q) begin
            if (counter_q == TARGET) begin
                counter_d = (RESET_IF_REACHED != 0) ? INITIAL : counter_q;
            end else if (counter_q == COUNT_MAX) begin
                counter_d = '0;
            end else begin
                counter_d = counter_q + COUNT_ONE;
            end
        end
    end

    // The first edge after reset only loads INITIAL; events are ignored on it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            counter_q      <= '0;
            reached_q      <= 1'b0;
            load_pending_q <= 1'b1;
        end else if (load_pending_q) begin
            counter_q      <= INITIAL;
            reached_q      <= (INITIAL == TARGET);
            load_pending_q <= 1'b0;
        end else begin
            counter_q      <= counter_d;
            reached_q      <= (counter_d == TARGET);
        end
    end

    assign COUNTER = counter_q;
    assign REACHED = reached_q;

endmodule

// File: tb/tb_event_ctr.sv
// Directed self-checking bench for event_ctr covering four parameterisations sharing clock/reset/TICK/ENABLE.
// Expected values are hand-derived; SYNC_LAT accounts for the optional TICK synchroniser.
module tb_event_ctr;

    localparam int SYNC_LAT =
`ifdef EVENT_CTR_TICK_SYNC_EN
        2;
`else
        0;
`endif

    logic       ACLK;
    logic       ARESETN;
    logic       ENABLE;
    logic       TICK;
    logic [3:0] initA, tgtA, initS, tgtS, initC, tgtC, initN, tgtN;
    logic [3:0] cntA, cntS, cntC, cntN;
    logic       rchA, rchS, rchC, rchN;

    int errors = 0;
    int checks = 0;

    // A: TICK events, enable, reload.  S: saturating.  C: clock events.  N: enable ignored.
    event_ctr #(.TARGET_WIDTH(4), .EVENT_IS_CLOCK(0), .HAS_ENABLE(1), .RESET_IF_REACHED(1)) u_a (
        .ACLK(ACLK), .ARESETN(ARESETN), .ENABLE(ENABLE), .INITIAL(initA), .TARGET(tgtA),
        .TICK(TICK), .REACHED(rchA), .COUNTER(cntA));
    event_ctr #(.TARGET_WIDTH(4), .EVENT_IS_CLOCK(0), .HAS_ENABLE(1), .RESET_IF_REACHED(0)) u_s (
        .ACLK(ACLK), .ARESETN(ARESETN), .ENABLE(ENABLE), .INITIAL(initS), .TARGET(tgtS),
        .TICK(TICK), .REACHED(rchS), .COUNTER(cntS));
    event_ctr #(.TARGET_WIDTH(4), .EVENT_IS_CLOCK(1), .HAS_ENABLE(1), .RESET_IF_REACHED(1)) u_c (
        .ACLK(ACLK), .ARESETN(ARESETN), .ENABLE(ENABLE), .INITIAL(initC), .TARGET(tgtC),
        .TICK(TICK), .REACHED(rchC), .COUNTER(cntC));
    event_ctr #(.TARGET_WIDTH(4), .EVENT_IS_CLOCK(0), .HAS_ENABLE(0), .RESET_IF_REACHED(1)) u_n (
        .ACLK(ACLK), .ARESETN(ARESETN), .ENABLE(ENABLE), .INITIAL(initN), .TARGET(tgtN),
        .TICK(TICK), .REACHED(rchN), .COUNTER(cntN));

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // One TICK pulse, then enough low cycles for the event to land even through the synchroniser.
    task automatic applyStimulus();
        TICK = 1'b1;
        step();
        TICK = 1'b0;
        step();
        repeat (SYNC_LAT) step();
    endtask

    task automatic resetDut();
        ARESETN = 1'b0;
        #2;
        ARESETN = 1'b1;
        step();
    endtask

    initial begin
        int n;
        ARESETN = 1'b0;
        ENABLE  = 1'b0;
        TICK    = 1'b0;
        initA = 4'd0;  tgtA = 4'd6;
        initS = 4'd0;  tgtS = 4'd6;
        initC = 4'd2;  tgtC = 4'd5;
        initN = 4'd0;  tgtN = 4'd15;

        #12;
        checkOutput("reset_cnt", 32'(cntA), 32'd0);
        checkOutput("reset_rch", 32'(rchA), 32'd0);
        checkOutput("reset_cntC", 32'(cntC), 32'd0);
        ARESETN = 1'b1;
        step();
        checkOutput("load_cntA", 32'(cntA), 32'd0);
        checkOutput("load_rchA", 32'(rchA), 32'd0);
        checkOutput("load_cntC", 32'(cntC), 32'd2);

        applyStimulus();
        checkOutput("disabled_cntA", 32'(cntA), 32'd0);
        checkOutput("noen_cntN", 32'(cntN), 32'd1);
        checkOutput("disabled_cntC", 32'(cntC), 32'd2);

        ENABLE = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus();
            checkOutput("basic_cnt", 32'(cntA), 32'(i));
            checkOutput("basic_rch", 32'(rchA), 32'(i == 6));
        end
        applyStimulus();
        checkOutput("reload_cnt", 32'(cntA), 32'd0);
        checkOutput("reload_rch", 32'(rchA), 32'd0);
        checkOutput("sat_cnt", 32'(cntS), 32'd6);
        checkOutput("sat_rch", 32'(rchS), 32'd1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus();
            checkOutput("sat_hold_cnt", 32'(cntS), 32'd6);
            checkOutput("sat_hold_rch", 32'(rchS), 32'd1);
        end

        resetDut();
        repeat (3) applyStimulus();
        checkOutput("gate_pre", 32'(cntA), 32'd3);
        ENABLE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("gate_hold", 32'(cntA), 32'd3);
        end
        ENABLE = 1'b1;
        for (int i = 4; i <= 6; i++) begin
            applyStimulus();
            checkOutput("gate_resume_cnt", 32'(cntA), 32'(i));
            checkOutput("gate_resume_rch", 32'(rchA), 32'(i == 6));
        end

        initA = 4'd14;
        tgtA  = 4'd1;
        resetDut();
        checkOutput("wrap_load", 32'(cntA), 32'd14);
        applyStimulus();
        checkOutput("wrap_15", 32'(cntA), 32'd15);
        applyStimulus();
        checkOutput("wrap_0", 32'(cntA), 32'd0);
        checkOutput("wrap_0_rch", 32'(rchA), 32'd0);
        applyStimulus();
        checkOutput("wrap_1", 32'(cntA), 32'd1);
        checkOutput("wrap_1_rch", 32'(rchA), 32'd1);
        applyStimulus();
        checkOutput("wrap_reload", 32'(cntA), 32'd14);
        checkOutput("wrap_reload_rch", 32'(rchA), 32'd0);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        ARESETN = 1'b0;
        #1;
        checkOutput("midreset_cnt", 32'(cntA), 32'd0);
        checkOutput("midreset_rch", 32'(rchA), 32'd0);
        #1;
        ARESETN = 1'b1;
        step();
        checkOutput("midreset_reload", 32'(cntA), 32'd14);

        initA = 4'd5;
        tgtA  = 4'd5;
        resetDut();
        checkOutput("eq_load_rch", 32'(rchA), 32'd1);
        applyStimulus();
        checkOutput("eq_evt_cnt", 32'(cntA), 32'd5);
        checkOutput("eq_evt_rch", 32'(rchA), 32'd1);

        resetDut();
        checkOutput("clk_load", 32'(cntC), 32'd2);
        for (int k = 1; k <= 8; k++) begin
            step();
            checkOutput("clk_cnt", 32'(cntC), 32'(2 + (k % 4)));
            checkOutput("clk_rch", 32'(rchC), 32'((k % 4) == 3));
        end
        ENABLE = 1'b0;
        step();
        checkOutput("clk_disabled", 32'(cntC), 32'd2);
        ENABLE = 1'b1;

        initA = 4'd0;
        tgtA  = 4'd15;
        resetDut();
        TICK = 1'b1;
        n = 0;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (n == 0 && cntA != 4'd0) n = e;
        end
        checkOutput("tick_latency", 32'(n), 32'(SYNC_LAT + 1));
        checkOutput("tick_held_once", 32'(cntA), 32'd1);
        TICK = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
